// File: rtl/rx_frame_commit_buffer.sv
// Receive frame store: bytes are written speculatively into a circular RAM,
// then committed or rolled back on the CRC verdict. Committed frames stream
// out as a valid/ready byte stream with sof/eof markers.
module rx_frame_commit_buffer #(
    parameter int ADDR_W         = 11,
    parameter int LEN_FIFO_DEPTH = 8,
    parameter int MAX_FRAME      = 1522,
    parameter int MIN_FRAME      = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic        crc_done,
    input  logic        fcs_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);
    localparam int PW = ADDR_W + 1;
    localparam int LW = 11;
    localparam int FW = $clog2(LEN_FIFO_DEPTH);
    localparam logic [LW-1:0] MAX_LEN    = LW'(MAX_FRAME);
    localparam logic [LW-1:0] MIN_LEN    = LW'(MIN_FRAME);
    localparam logic [PW-1:0] RAM_BYTES  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [FW:0]   LF_ENTRIES = {1'b1, {FW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_CRC  = 2'd2,
        ST_DROP_WAIT = 2'd3   // verdict pending for a frame already condemned
    } wr_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [7:0]    mem [2**ADDR_W];
    logic [LW-1:0] lf_mem [LEN_FIFO_DEPTH];

    wr_state_t     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] fetch_ptr_q, fetch_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] len_q, len_d, rem_q, rem_d;
    logic          drop_q, drop_d;
    logic [15:0]   frames_ok_q, frames_ok_d, frames_dropped_q, frames_dropped_d;
    logic [FW:0]   lf_wp_q, lf_wp_d, lf_rp_q, lf_rp_d, lf_free_q, lf_free_d;
    logic          out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          we_s, push_s, frame_end_s, verdict_s, full_s, lf_full_s, lf_empty_s;
    logic [LW-1:0] lf_head_s;

    // rd_ptr only advances on a handshake, so a byte still held in the output
    // register keeps its RAM slot; frames stay counted until their eof leaves.
    assign full_s     = ((wr_ptr_q - rd_ptr_q) == RAM_BYTES);
    assign lf_full_s  = ((lf_wp_q - lf_free_q) == LF_ENTRIES);
    assign lf_empty_s = (lf_wp_q == lf_rp_q);
    assign lf_head_s  = lf_mem[lf_rp_q[FW-1:0]];

    // Write FSM next-state, speculative write pointer and commit/rollback decision.
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        commit_ptr_d     = commit_ptr_q;
        len_d            = len_q;
        drop_d           = drop_q;
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;
        lf_wp_d          = lf_wp_q;
        we_s             = 1'b0;
        push_s           = 1'b0;
        frame_end_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    len_d = 11'd1;
                    if (in_eof) begin
                        drop_d      = 1'b1;
                        frame_end_s = 1'b1;
                        state_d     = ST_DROP_WAIT;
                    end else if (full_s) begin
                        drop_d  = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        drop_d   = 1'b0;
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + 12'(1);
                        state_d  = ST_WRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        drop_d = 1'b1;
                    end else if (drop_q) begin
                        drop_d = 1'b1;
                    end else if (full_s || (len_q >= MAX_LEN)) begin
                        drop_d = 1'b1;
                    end else begin
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + 12'(1);
                        len_d    = len_q + 11'd1;
                    end
                    if (in_eof) begin
                        frame_end_s = 1'b1;
                        state_d     = drop_d ? ST_DROP_WAIT : ST_WAIT_CRC;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT_CRC:  state_d = ST_WAIT_CRC;
            ST_DROP_WAIT: state_d = ST_DROP_WAIT;
            default:      state_d = ST_IDLE;
        endcase

        // The verdict may coincide with the eof byte, so it is judged on the
        // post-eof pointer and length.
        verdict_s = crc_done && (frame_end_s || (state_q == ST_WAIT_CRC) ||
                                 (state_q == ST_DROP_WAIT));
        if (verdict_s) begin
            state_d = ST_IDLE;
            if (!fcs_error && !drop_d && (len_d >= MIN_LEN) && !lf_full_s) begin
                commit_ptr_d = wr_ptr_d;
                push_s       = 1'b1;
                lf_wp_d      = lf_wp_q + 4'(1);
                frames_ok_d  = sat_inc(frames_ok_q);
            end else begin
                wr_ptr_d         = commit_ptr_q;
                frames_dropped_d = sat_inc(frames_dropped_q);
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Read side: refill the output register whenever it is empty or being taken.
    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        rem_d       = rem_q;
        lf_rp_d     = lf_rp_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        if (out_valid_q && out_ready) begin
            rd_ptr_d  = rd_ptr_q + 12'(1);
            lf_free_d = out_eof_q ? (lf_free_q + 4'(1)) : lf_free_q;
        end else begin
            rd_ptr_d  = rd_ptr_q;
            lf_free_d = lf_free_q;
        end
        if (!out_valid_q || out_ready) begin
            if (rem_q != 11'd0) begin
                out_valid_d = 1'b1;
                out_data_d  = mem[fetch_ptr_q[ADDR_W-1:0]];
                out_sof_d   = 1'b0;
                out_eof_d   = (rem_q == 11'd1);
                rem_d       = rem_q - 11'd1;
                fetch_ptr_d = fetch_ptr_q + 12'(1);
            end else if (!lf_empty_s) begin
                out_valid_d = 1'b1;
                out_data_d  = mem[fetch_ptr_q[ADDR_W-1:0]];
                out_sof_d   = 1'b1;
                out_eof_d   = (lf_head_s == 11'd1);
                rem_d       = lf_head_s - 11'd1;
                fetch_ptr_d = fetch_ptr_q + 12'(1);
                lf_rp_d     = lf_rp_q + 4'(1);
            end else begin
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_eof_d   = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Byte RAM and length FIFO storage (contents need no reset).
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= in_data;
        end
        if (push_s) begin
            lf_mem[lf_wp_q[FW-1:0]] <= len_d;
        end
    end

    // State, pointers, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            commit_ptr_q     <= '0;
            fetch_ptr_q      <= '0;
            rd_ptr_q         <= '0;
            len_q            <= '0;
            rem_q            <= '0;
            drop_q           <= 1'b0;
            frames_ok_q      <= 16'd0;
            frames_dropped_q <= 16'd0;
            lf_wp_q          <= '0;
            lf_rp_q          <= '0;
            lf_free_q        <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= 8'd0;
            out_sof_q        <= 1'b0;
            out_eof_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            commit_ptr_q     <= commit_ptr_d;
            fetch_ptr_q      <= fetch_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            len_q            <= len_d;
            rem_q            <= rem_d;
            drop_q           <= drop_d;
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
            lf_wp_q          <= lf_wp_d;
            lf_rp_q          <= lf_rp_d;
            lf_free_q        <= lf_free_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_sof_q        <= out_sof_d;
            out_eof_q        <= out_eof_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_sof        = out_sof_q;
    assign out_eof        = out_eof_q;
    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
endmodule

// File: tb/tb_rx_frame_commit_buffer.sv
// Bench for rx_frame_commit_buffer: directed frames, a frame-level model of
// which frames must survive, and a per-cycle compare of the output stream.
module tb_rx_frame_commit_buffer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        crc_done = 1'b0, fcs_error = 1'b0;
    logic        out_valid, out_sof, out_eof;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [15:0] frames_ok, frames_dropped;

    rx_frame_commit_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
        .crc_done(crc_done), .fcs_error(fcs_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof),
        .frames_ok(frames_ok), .frames_dropped(frames_dropped)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state. Driver owns the committed side, the compare process the consumed side.
    logic [7:0] exp_data [16384];
    logic       exp_sof  [16384];
    logic       exp_eof  [16384];
    int exp_wr = 0, exp_rd = 0;
    int committed_bytes = 0, committed_frames = 0;
    int consumed_bytes = 0, consumed_frames = 0;
    int m_ok = 0, m_drop = 0;
    int frame_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame-level rule: a good frame survives only if its size is legal and
    // both the byte store and the frame count have room for it.
    task automatic verdict(input int fid, input int len, input bit bad);
        int pend_b, pend_f;
        pend_b = committed_bytes - consumed_bytes;
        pend_f = committed_frames - consumed_frames;
        if (!bad && len >= 64 && len <= 1522 && pend_f < 8 && pend_b + len <= 2048) begin
            for (int i = 0; i < len; i++) begin
                exp_data[(exp_wr + i) & 16383] = 8'(fid * 7 + i);
                exp_sof[(exp_wr + i) & 16383]  = (i == 0);
                exp_eof[(exp_wr + i) & 16383]  = (i == len - 1);
            end
            exp_wr           += len;
            committed_bytes  += len;
            committed_frames += 1;
            if (m_ok < 65535) m_ok++;
        end else begin
            if (m_drop < 65535) m_drop++;
        end
    endtask

    // gap = cycles from eof to crc_done (0 = same cycle).
    task automatic send_frame(input int len, input bit bad, input int gap);
        int fid;
        fid = frame_id;
        frame_id++;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(fid * 7 + i);
            in_sof   = (i == 0);
            in_eof   = (i == len - 1);
            if (i == len - 1 && gap == 0) begin
                crc_done  = 1'b1;
                fcs_error = bad;
            end
            tick();
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        if (gap > 0) begin
            repeat (gap - 1) tick();
            crc_done  = 1'b1;
            fcs_error = bad;
            tick();
        end
        crc_done  = 1'b0;
        fcs_error = 1'b0;
        verdict(fid, len, bad);
    endtask

    task automatic do_reset;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; crc_done = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sof", {31'd0, out_sof}, 32'd0);
        check("rst_out_eof", {31'd0, out_eof}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_frames_ok", {16'd0, frames_ok}, 32'd0);
        check("rst_frames_dropped", {16'd0, frames_dropped}, 32'd0);
        repeat (2) tick();
        m_ok = 0;
        m_drop = 0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (exp_rd != exp_wr && b > 0) begin
            tick();
            b--;
        end
        check("drain_remaining", exp_wr - exp_rd, 32'd0);
    endtask

    // Per-cycle compare of outputs against the model, plus hold-under-stall.
    initial begin
        logic pv, pr, ps, pe;
        logic [7:0] pd;
        bit have_prev;
        have_prev = 0;
        pv = 0; pr = 0; ps = 0; pe = 0; pd = 8'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_rd          = exp_wr;
                consumed_bytes  = committed_bytes;
                consumed_frames = committed_frames;
                have_prev       = 0;
            end else begin
                check("frames_ok", {16'd0, frames_ok}, m_ok);
                check("frames_dropped", {16'd0, frames_dropped}, m_drop);
                if (have_prev && pv && !pr)
                    check("stall_hold", {21'd0, out_valid, out_sof, out_eof, out_data},
                          {21'd0, 1'b1, ps, pe, pd});
                if (out_valid && exp_rd == exp_wr) begin
                    check("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
                end else if (out_valid && out_ready) begin
                    check("out_byte", {22'd0, out_sof, out_eof, out_data},
                          {22'd0, exp_sof[exp_rd & 16383], exp_eof[exp_rd & 16383],
                           exp_data[exp_rd & 16383]});
                    if (exp_eof[exp_rd & 16383]) consumed_frames++;
                    exp_rd++;
                    consumed_bytes++;
                end
                pv = out_valid; pr = out_ready; ps = out_sof; pe = out_eof; pd = out_data;
                have_prev = 1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Good 64-byte frame, verdict two cycles after eof.
        do_reset();
        out_ready = 1'b1;
        base = consumed_bytes;
        send_frame(64, 1'b0, 2);
        drain(200);
        check("t1_bytes_out", consumed_bytes - base, 32'd64);
        check("t1_frames_ok", {16'd0, frames_ok}, 32'd1);

        // Bad FCS rolls back; next good frame reads out intact.
        do_reset();
        out_ready = 1'b1;
        base = consumed_bytes;
        send_frame(64, 1'b1, 2);
        repeat (5) tick();
        check("t2_dropped", {16'd0, frames_dropped}, 32'd1);
        check("t2_no_bytes", consumed_bytes - base, 32'd0);
        send_frame(100, 1'b0, 1);
        drain(300);
        check("t2_bytes_out", consumed_bytes - base, 32'd100);

        // Size limits: 60 and 1530 dropped, 1522 accepted, 63 dropped.
        do_reset();
        out_ready = 1'b1;
        base = consumed_bytes;
        send_frame(60, 1'b0, 1);
        send_frame(1530, 1'b0, 0);
        check("t3_dropped_two", {16'd0, frames_dropped}, 32'd2);
        send_frame(1522, 1'b0, 1);
        send_frame(63, 1'b0, 2);
        drain(3000);
        check("t3_bytes_out", consumed_bytes - base, 32'd1522);
        check("t3_frames_ok", {16'd0, frames_ok}, 32'd1);
        check("t3_dropped_three", {16'd0, frames_dropped}, 32'd3);

        // RAM overflow with the reader stalled.
        do_reset();
        out_ready = 1'b0;
        base = consumed_bytes;
        for (int k = 0; k < 3; k++) send_frame(700, 1'b0, 2);
        check("t4_ok", {16'd0, frames_ok}, 32'd2);
        check("t4_dropped", {16'd0, frames_dropped}, 32'd1);
        out_ready = 1'b1;
        drain(3000);
        check("t4_bytes_out", consumed_bytes - base, 32'd1400);
        send_frame(700, 1'b0, 1);
        drain(1000);
        check("t4_ok_after", {16'd0, frames_ok}, 32'd3);

        // Length FIFO full with the reader stalled.
        do_reset();
        out_ready = 1'b0;
        base = consumed_bytes;
        for (int k = 0; k < 9; k++) send_frame(64, 1'b0, 1);
        check("t5_ok", {16'd0, frames_ok}, 32'd8);
        check("t5_dropped", {16'd0, frames_dropped}, 32'd1);
        out_ready = 1'b1;
        drain(1000);
        check("t5_bytes_out", consumed_bytes - base, 32'd512);

        // Reset mid-readout and mid-write, then a normal frame.
        do_reset();
        out_ready = 1'b1;
        send_frame(300, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_eof   = 1'b0;
            in_data  = 8'(i);
            tick();
        end
        do_reset();
        out_ready = 1'b1;
        base = consumed_bytes;
        send_frame(64, 1'b0, 0);
        drain(200);
        check("t6_bytes_out", consumed_bytes - base, 32'd64);
        check("t6_frames_ok", {16'd0, frames_ok}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
